// File: rtl/pulse_code_pkg.sv
// ============================================================================
// Module : pulse_code_pkg
// Brief  : Shared constants, state encoding and code legality helper for the
//          pulse code decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_code_pkg;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_MIN  = 4'd1;
  localparam logic [3:0] CODE_MAX  = 4'd9;
  localparam int         N_LINES   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Code 0 counts as legal: it is a valid "no line" request.
  function automatic logic is_legal_code(input logic [3:0] code);
    return (code <= CODE_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_code_decoder_if.sv
// ============================================================================
// Module : pulse_code_decoder_if
// Brief  : Code handshake and line outputs between producer and decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pulse_code_decoder_if;
  import pulse_code_pkg::*;

  logic               in_valid;
  logic [3:0]         in_code;
  logic               in_ready;
  logic [N_LINES-1:0] out;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output in_valid, in_code,
    input  in_ready, out, busy, done, err
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/code_onehot_dec.sv
// ============================================================================
// Module : code_onehot_dec
// Brief  : 4-bit code to one-hot line select; zero for code 0 and 10..15.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module code_onehot_dec
  import pulse_code_pkg::*;
(
  input  logic [3:0]         code,
  output logic [N_LINES-1:0] onehot
);

  for (genvar k = 0; k < N_LINES; k++) begin : g_line
    assign onehot[k] = (code == (4'(k) + CODE_MIN));
  end

endmodule

`default_nettype wire

// File: rtl/pulse_code_decoder.sv
// ============================================================================
// Module : pulse_code_decoder
// Brief  : Accepts a code over valid/ready and pulses the matching line for
//          PULSE_LEN cycles, then idles GAP_LEN cycles before the next accept.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_code_decoder
  import pulse_code_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_code_decoder_if.slave  bus
);

  localparam logic [7:0] c_pulse_reload = 8'(PULSE_LEN - 1);
  localparam logic [7:0] c_gap_reload   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic [N_LINES-1:0] r_out;
  logic               r_done;
  logic               r_err;
  logic [N_LINES-1:0] w_onehot;
  logic               w_idle;

  code_onehot_dec u_dec (
    .code   (bus.in_code),
    .onehot (w_onehot)
  );

  assign w_idle       = (r_state == IDLE);
  assign bus.in_ready = w_idle;
  assign bus.busy     = !w_idle;
  assign bus.out      = r_out;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (!is_legal_code(bus.in_code)) begin
              r_err <= 1'b1;
            end else if (bus.in_code != CODE_NONE) begin
              r_out   <= w_onehot;
              r_cnt   <= c_pulse_reload;
              // A one-cycle pulse enters its final cycle straight from IDLE.
              r_done  <= (c_pulse_reload == 8'd0);
              r_state <= PULSE;
            end
          end
        end
        PULSE: begin
          if (r_cnt == 8'd0) begin
            r_out <= '0;
            if (GAP_LEN == 0) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= c_gap_reload;
              r_state <= GAP;
            end
          end else begin
            r_cnt  <= r_cnt - 8'd1;
            r_done <= (r_cnt == 8'd1);
          end
        end
        GAP: begin
          r_out <= '0;
          if (r_cnt == 8'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_out   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_code_decoder.sv
// ============================================================================
// Module : tb_pulse_code_decoder
// Brief  : Directed vector table plus hand-written corner sequences for the
//          pulse code decoder (default timing and PULSE_LEN=1/GAP_LEN=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_code_decoder;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic [8:0] exp_out;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  vec_t vecs[$];

  pulse_code_decoder_if ifa ();
  pulse_code_decoder_if ifb ();

  pulse_code_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  pulse_code_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] c, input logic [8:0] o,
                     input logic r, input logic b, input logic d, input logic e);
    vec_t t;
    t.valid = v; t.code = c; t.exp_out = o;
    t.exp_ready = r; t.exp_busy = b; t.exp_done = d; t.exp_err = e;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev_acc;
    int n;
    logic [8:0] exp1h;

    checks = 0;
    errors = 0;

    // valid code  out           rdy  busy done err
    add(1, 4'd5,  9'b000010000, 0, 1, 0, 0);
    add(1, 4'd5,  9'b000010000, 0, 1, 0, 0);
    add(1, 4'd5,  9'b000010000, 0, 1, 0, 0);
    add(1, 4'd5,  9'b000010000, 0, 1, 1, 0);
    add(1, 4'd5,  9'b000000000, 0, 1, 0, 0);
    add(1, 4'd5,  9'b000000000, 1, 0, 0, 0);
    add(1, 4'd5,  9'b000010000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000010000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000010000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000010000, 0, 1, 1, 0);
    add(0, 4'd0,  9'b000000000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000000000, 1, 0, 0, 0);
    add(1, 4'd0,  9'b000000000, 1, 0, 0, 0);
    add(1, 4'd10, 9'b000000000, 1, 0, 0, 1);
    add(1, 4'd15, 9'b000000000, 1, 0, 0, 1);
    add(0, 4'd3,  9'b000000000, 1, 0, 0, 0);
    add(1, 4'd2,  9'b000000010, 0, 1, 0, 0);
    add(0, 4'd7,  9'b000000010, 0, 1, 0, 0);
    add(1, 4'd8,  9'b000000010, 0, 1, 0, 0);
    add(0, 4'd9,  9'b000000010, 0, 1, 1, 0);
    add(1, 4'd12, 9'b000000000, 0, 1, 0, 0);
    add(1, 4'd6,  9'b000000000, 1, 0, 0, 0);
    add(1, 4'd6,  9'b000100000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000100000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000100000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000100000, 0, 1, 1, 0);
    add(0, 4'd0,  9'b000000000, 0, 1, 0, 0);
    add(0, 4'd0,  9'b000000000, 1, 0, 0, 0);

    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_code = 4'd0;
    ifb.in_valid = 1'b0; ifb.in_code = 4'd0;
    repeat (2) step();
    chk("rst_out",   ifa.out, 9'd0);
    chk("rst_ready", 9'(ifa.in_ready), 9'd1);
    chk("rst_busy",  9'(ifa.busy), 9'd0);
    chk("rst_done",  9'(ifa.done), 9'd0);
    chk("rst_err",   9'(ifa.err), 9'd0);
    chk("rst_b_out", ifb.out, 9'd0);
    rst_n = 1'b1;
    step();

    // Table: default timing, handshake, illegal codes, changes during PULSE.
    for (int i = 0; i < vecs.size(); i++) begin
      ifa.in_valid = vecs[i].valid;
      ifa.in_code  = vecs[i].code;
      step();
      chk($sformatf("vec%0d_out", i),   ifa.out, vecs[i].exp_out);
      chk($sformatf("vec%0d_ready", i), 9'(ifa.in_ready), 9'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i),  9'(ifa.busy), 9'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i),  9'(ifa.done), 9'(vecs[i].exp_done));
      chk($sformatf("vec%0d_err", i),   9'(ifa.err), 9'(vecs[i].exp_err));
    end

    // Sweep 1..9 back-to-back with in_valid held high.
    prev_acc = 0;
    for (int c = 1; c <= 9; c++) begin
      ifa.in_code  = 4'(c);
      ifa.in_valid = 1'b1;
      n = 0;
      while (!ifa.in_ready && n < 20) begin
        step();
        n++;
        chk("sweep_onehot", 9'($countones(ifa.out) <= 1), 9'd1);
      end
      if (!ifa.in_ready) begin
        chk("sweep_ready_timeout", 9'(ifa.in_ready), 9'd1);
      end
      step();
      exp1h = 9'd1 << (c - 1);
      chk($sformatf("sweep_out_c%0d", c), ifa.out, exp1h);
      if (c > 1) chk($sformatf("sweep_space_c%0d", c), 9'(cyc - prev_acc), 9'd6);
      prev_acc = cyc;
    end
    ifa.in_valid = 1'b0;
    n = 0;
    while (!ifa.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("sweep_drain_ready", 9'(ifa.in_ready), 9'd1);

    // PULSE_LEN=1, GAP_LEN=0: codes 9 then 1, accepts two cycles apart.
    ifb.in_valid = 1'b1;
    ifb.in_code  = 4'd9;
    step();
    chk("b_out9",   ifb.out, 9'b100000000);
    chk("b_done9",  9'(ifb.done), 9'd1);
    chk("b_busy9",  9'(ifb.busy), 9'd1);
    ifb.in_code = 4'd1;
    step();
    chk("b_gap_out",   ifb.out, 9'd0);
    chk("b_gap_ready", 9'(ifb.in_ready), 9'd1);
    chk("b_gap_done",  9'(ifb.done), 9'd0);
    step();
    chk("b_out1",  ifb.out, 9'b000000001);
    chk("b_done1", 9'(ifb.done), 9'd1);
    ifb.in_valid = 1'b0;
    step();
    chk("b_end_out",   ifb.out, 9'd0);
    chk("b_end_ready", 9'(ifb.in_ready), 9'd1);

    // Asynchronous reset on the second pulse cycle of code 3.
    ifa.in_valid = 1'b1;
    ifa.in_code  = 4'd3;
    step();
    chk("rp_out1", ifa.out, 9'b000000100);
    ifa.in_valid = 1'b0;
    step();
    chk("rp_out2", ifa.out, 9'b000000100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rp_async_out",   ifa.out, 9'd0);
    chk("rp_async_busy",  9'(ifa.busy), 9'd0);
    chk("rp_async_ready", 9'(ifa.in_ready), 9'd1);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("rp_post_out", ifa.out, 9'd0);
    end
    chk("rp_post_ready", 9'(ifa.in_ready), 9'd1);
    chk("rp_post_done",  9'(ifa.done), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
